fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the 9-bit instruction decoder.
- Holds the program counter and the instruction memory. Presents the current instruction to the decoder combinationally.
- Next-PC selection each cycle is driven by the decoder's jump/halt outputs and the ALU branch compare.
- Also owns the run-control state machine (idle / run / halted), a program-load port, and a cycle counter.

---
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: run control, program load, decoder/ALU feedback and
// the fetched instruction/PC/status returned to the decoder side.
interface fetch_unit_if #(
   parameter int PC_WIDTH     = 10,
   parameter int INSTR_WIDTH  = 9,
   parameter int OFFSET_WIDTH = 6,
   parameter int CNT_WIDTH    = 16
);
   logic                    start;
   logic [PC_WIDTH-1:0]     start_addr;
   logic                    load_en;
   logic [PC_WIDTH-1:0]     load_addr;
   logic [INSTR_WIDTH-1:0]  load_data;
   logic                    jump;
   logic [OFFSET_WIDTH-1:0] jump_offset;
   logic                    branch;
   logic                    branch_eq;
   logic                    halt;
   logic [INSTR_WIDTH-1:0]  instruction;
   logic [PC_WIDTH-1:0]     pc;
   logic                    valid;
   logic                    done;
   logic [CNT_WIDTH-1:0]    cycle_count;

   // Decoder / controller side
   modport master (
      output start, start_addr, load_en, load_addr, load_data,
             jump, jump_offset, branch, branch_eq, halt,
      input  instruction, pc, valid, done, cycle_count
   );

   // Fetch unit side
   modport slave (
      input  start, start_addr, load_en, load_addr, load_data,
             jump, jump_offset, branch, branch_eq, halt,
      output instruction, pc, valid, done, cycle_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction memory with load port,
// idle/run/halted control and a saturating run-cycle counter.
module fetch_unit #(
   parameter int PC_WIDTH     = 10,
   parameter int INSTR_WIDTH  = 9,
   parameter int OFFSET_WIDTH = 6,
   parameter int CNT_WIDTH    = 16
) (
   input logic         clk,
   input logic         reset,
   fetch_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

   state_e                 state_q;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   valid_q, done_q;
   logic [PC_WIDTH-1:0]    off_ext;
   logic [INSTR_WIDTH-1:0] mem_q [2**PC_WIDTH];

   assign off_ext = {{(PC_WIDTH-OFFSET_WIDTH){bus.jump_offset[OFFSET_WIDTH-1]}},
                     bus.jump_offset};

   // Next PC while running (halt handled in the FSM); wraps naturally.
   always_comb begin
      pc_d = pc_q + PC_WIDTH'(1);
      if (bus.jump)
         pc_d = pc_q + off_ext;
      else if (bus.branch && bus.branch_eq)
         pc_d = pc_q + PC_WIDTH'(2);
   end

   // Run-control FSM with registered PC, counter and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, HALTED: begin
               if (bus.start) begin
                  state_q <= RUN;
                  pc_q    <= bus.start_addr;
                  cnt_q   <= '0;
                  valid_q <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            RUN: begin
               if (cnt_q != '1)
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               if (bus.halt) begin
                  state_q <= HALTED;
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  pc_q <= pc_d;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Program load; memory is never cleared and writes are locked out in RUN.
   always_ff @(posedge clk) begin
      if (!reset && bus.load_en && state_q != RUN)
         mem_q[bus.load_addr] <= bus.load_data;
   end

   assign bus.instruction = mem_q[pc_q];
   assign bus.pc          = pc_q;
   assign bus.valid       = valid_q;
   assign bus.done        = done_q;
   assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; counter narrowed so saturation is reachable.
module tb_fetch_unit;
   localparam int PW = 10, IW = 9, OW = 6, CW = 4;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .OFFSET_WIDTH(OW), .CNT_WIDTH(CW)) fif ();

   fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .OFFSET_WIDTH(OW), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (fif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [PW-1:0] a, input logic [IW-1:0] d);
      fif.load_en = 1'b1; fif.load_addr = a; fif.load_data = d;
      tick();
      fif.load_en = 1'b0;
   endtask

   task automatic do_start(input logic [PW-1:0] a);
      fif.start = 1'b1; fif.start_addr = a;
      tick();
      fif.start = 1'b0;
   endtask

   task automatic do_jump(input logic [OW-1:0] off);
      fif.jump = 1'b1; fif.jump_offset = off;
      tick();
      fif.jump = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      fif.start = 0; fif.start_addr = '0; fif.load_en = 0; fif.load_addr = '0;
      fif.load_data = '0; fif.jump = 0; fif.jump_offset = '0; fif.branch = 0;
      fif.branch_eq = 0; fif.halt = 0;
      tick(); tick();
      chk("rst_pc", 32'(fif.pc), 0);
      chk("rst_valid", 32'(fif.valid), 0);
      chk("rst_done", 32'(fif.done), 0);
      chk("rst_cnt", 32'(fif.cycle_count), 0);
      reset = 1'b0;

      // Program: three words, HALT at 3, marker at 9
      load(10'd1, 9'h022);
      load(10'd2, 9'h033);
      load(10'd3, 9'b111000011);
      load(10'd9, 9'h099);
      // start together with load of the start address
      fif.load_en = 1'b1; fif.load_addr = 10'd0; fif.load_data = 9'h011;
      do_start(10'd0);
      fif.load_en = 1'b0;
      chk("seq_pc0", 32'(fif.pc), 0);
      chk("seq_valid", 32'(fif.valid), 1);
      chk("seq_instr0", 32'(fif.instruction), 32'h011);
      chk("seq_cnt0", 32'(fif.cycle_count), 0);
      tick();
      chk("seq_pc1", 32'(fif.pc), 1);
      chk("seq_instr1", 32'(fif.instruction), 32'h022);
      do_start(10'd500); // ignored in RUN
      chk("seq_pc2_start_ign", 32'(fif.pc), 2);
      tick();
      chk("seq_pc3", 32'(fif.pc), 3);
      chk("seq_instr3", 32'(fif.instruction), 32'h1C3);
      fif.halt = 1'b1; tick(); fif.halt = 1'b0;
      chk("seq_done", 32'(fif.done), 1);
      chk("seq_valid_off", 32'(fif.valid), 0);
      chk("seq_pc_hold", 32'(fif.pc), 3);
      chk("seq_cnt4", 32'(fif.cycle_count), 4);
      tick();
      chk("seq_pc_hold2", 32'(fif.pc), 3);
      chk("seq_cnt_hold", 32'(fif.cycle_count), 4);

      // Jumps
      do_start(10'd5);
      chk("jmp_start_pc", 32'(fif.pc), 5);
      chk("jmp_start_cnt", 32'(fif.cycle_count), 0);
      do_jump(6'd3);
      chk("jmp_pos", 32'(fif.pc), 8);
      do_jump(6'b111101);
      chk("jmp_neg", 32'(fif.pc), 5);
      do_jump(6'b111101);
      chk("jmp_to2", 32'(fif.pc), 2);
      do_jump(6'b111100);
      chk("jmp_wrap", 32'(fif.pc), 1022);
      do_jump(6'b100000);
      chk("jmp_m32", 32'(fif.pc), 990);
      do_jump(6'd0);
      chk("jmp_self", 32'(fif.pc), 990);
      chk("jmp_cnt", 32'(fif.cycle_count), 6);
      fif.halt = 1'b1; tick(); fif.halt = 1'b0;
      chk("jmp_halt_cnt", 32'(fif.cycle_count), 7);

      // PC wrap and load gating in RUN
      do_start(10'd1023);
      chk("wrap_start", 32'(fif.pc), 1023);
      fif.load_en = 1'b1; fif.load_addr = 10'd0; fif.load_data = 9'h1FF;
      tick();
      fif.load_en = 1'b0;
      chk("wrap_pc0", 32'(fif.pc), 0);
      chk("run_load_ign", 32'(fif.instruction), 32'h011);

      // Branches
      do_jump(6'd10);
      chk("br_setup", 32'(fif.pc), 10);
      fif.branch = 1'b1; fif.branch_eq = 1'b1; tick();
      fif.branch = 1'b0; fif.branch_eq = 1'b0;
      chk("br_taken", 32'(fif.pc), 12);
      do_jump(6'b111110);
      chk("br_back", 32'(fif.pc), 10);
      fif.branch = 1'b1; fif.branch_eq = 1'b0; tick();
      fif.branch = 1'b0;
      chk("br_not_taken", 32'(fif.pc), 11);

      // halt beats jump
      do_jump(6'b111100);
      chk("pri_setup", 32'(fif.pc), 7);
      fif.halt = 1'b1; fif.jump = 1'b1; fif.jump_offset = 6'd3; tick();
      fif.halt = 1'b0; fif.jump = 1'b0;
      chk("pri_pc", 32'(fif.pc), 7);
      chk("pri_done", 32'(fif.done), 1);
      chk("pri_valid", 32'(fif.valid), 0);
      chk("pri_cnt", 32'(fif.cycle_count), 7);

      // Loads in HALTED, restart
      load(10'd7, 9'h0AA);
      chk("hlt_load_cur", 32'(fif.instruction), 32'h0AA);
      chk("hlt_pc", 32'(fif.pc), 7);
      load(10'd20, 9'h155);
      do_start(10'd20);
      chk("rs_pc", 32'(fif.pc), 20);
      chk("rs_instr", 32'(fif.instruction), 32'h155);
      chk("rs_cnt", 32'(fif.cycle_count), 0);
      chk("rs_valid", 32'(fif.valid), 1);
      chk("rs_done", 32'(fif.done), 0);

      // Reset mid-run
      do_jump(6'b110101);
      chk("mr_pc9", 32'(fif.pc), 9);
      chk("mr_instr9", 32'(fif.instruction), 32'h099);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mr_pc", 32'(fif.pc), 0);
      chk("mr_valid", 32'(fif.valid), 0);
      chk("mr_done", 32'(fif.done), 0);
      chk("mr_cnt", 32'(fif.cycle_count), 0);
      tick();
      chk("mr_mem_kept", 32'(fif.instruction), 32'h011);
      chk("mr_idle_pc", 32'(fif.pc), 0);

      // Counter saturation
      do_start(10'd100);
      repeat (20) tick();
      chk("sat_cnt", 32'(fif.cycle_count), 15);
      chk("sat_pc", 32'(fif.pc), 120);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
